sensor_conditioner: RTL and testbench
=====================================

// Module: sensor_conditioner
// PURPOSE
//  Front-end stage between raw board switches and the irrigation system core. Synchronises
//  and debounces the six sensor inputs (tank levels h/m/l, soil us/ua, temperature t).
//  Checks tank-level plausibility and drives clean, glitch-free levels into the core's
//  h, m, l, us, ua and t inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  clk cycles an input must stay stable before it is accepted (>=2)
//  SYNC_STAGES      2      flip-flop depth of the input synchroniser (>=2)
// PORTS
//  clk        in   1  system clock, the same clock that feeds the core's delay dividers
//  rst_n      in   1  asynchronous, active-low reset
//  raw_h      in   1  tank-high switch, unsynchronised
//  raw_m      in   1  tank-mid switch, unsynchronised
//  raw_l      in   1  tank-low switch, unsynchronised
//  raw_us     in   1  soil-dry switch, unsynchronised
//  raw_ua     in   1  air-humidity switch, unsynchronised
//  raw_t      in   1  temperature switch, unsynchronised
//  h, m, l    out  1  conditioned tank levels; always a plausible pattern
//  us, ua, t  out  1  conditioned soil/air/temperature levels
//  changed    out  1  one-cycle pulse when any conditioned output changes
//  level_err  out  1  raw debounced tank pattern is implausible
//  err_clr    in   1  clears the sticky error (present only with SENSOR_FAULT_LATCH_EN)
// BEHAVIOUR
//  Reset: all outputs 0; synchronisers, counters and stable registers 0; channel FSMs in STABLE.
//  Per channel: SYNC_STAGES-FF synchroniser, then a 2-state FSM with counter
//  cnt[$clog2(DEBOUNCE_CYCLES)-1:0]:
//   STABLE : sync==stable -> stay, cnt=0.  sync!=stable -> PENDING, cnt=1.
//   PENDING: sync==stable -> STABLE, cnt=0 (glitch discarded, no output change).
//            sync!=stable and cnt==DEBOUNCE_CYCLES-1 -> stable<=sync, cnt=0, STABLE.
//            Otherwise cnt++. The counter never wraps.
//  Latency: a clean edge on raw_x reaches the debounced value SYNC_STAGES+DEBOUNCE_CYCLES
//   clk cycles later. A bounce inside the window restarts the full window.
//  Tank plausibility, on debounced values {h,m,l}:
//   - Valid patterns: 000, 001, 011, 111.
//   - Valid pattern: copied to the h/m/l outputs one cycle later, level_err=0.
//   - Invalid pattern (any higher level set without the one below it): h/m/l hold the
//     last valid pattern and level_err=1.
//  us/ua/t are registered copies of their debounced values; they have no plausibility check.
//  Simultaneous events:
//   - Channels settling in the same cycle update together.
//   - Exactly one changed pulse is produced for that cycle.
//   - changed is asserted in the same cycle the outputs change.
//  Reset mid-operation: every pending count is discarded. After release each input needs
//   a full SYNC_STAGES+DEBOUNCE_CYCLES window before it can assert.
// CONFIGURATION
//  SENSOR_FAULT_LATCH_EN defined:
//   - level_err is sticky. It sets on the first implausible pattern.
//   - It clears only on err_clr==1 while the current pattern is valid.
//   - err_clr asserted while the pattern is still invalid has no effect.
//  SENSOR_FAULT_LATCH_EN undefined:
//   - err_clr port is absent.
//   - level_err follows the current pattern each cycle.
// STRUCTURE
//  Package sensor_pkg: N_CH=6; channel indices CH_H=0, CH_M=1, CH_L=2, CH_US=3, CH_UA=4,
//   CH_T=5; FSM state encoding ST_STABLE/ST_PENDING; function level_valid(h,m,l).
//  Sub-module debounce_cell: synchroniser + FSM + counter for one bit, instantiated N_CH times.
//  The top level holds the plausibility logic, output registers and changed/err logic.
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1 Reset: hold rst_n=0, all raw_*=1 -> all outputs 0; release -> us/ua/t=1 after 6 cycles.
//  2 raw_us 0->1 held -> us=1 exactly 6 cycles after the edge, changed=1 for that cycle only.
//  3 raw_t high for 3 cycles then low -> t stays 0, changed never pulses.
//  4 raw_l, raw_m, raw_h rise 10 cycles apart -> h/m/l step 001, 011, 111, level_err=0;
//    then raw_m=0 -> level_err=1, h/m/l hold 111.
//  5 raw_ua high for 3 cycles, pulse rst_n low for 1 cycle, raw_ua kept high -> ua=0 until
//    a full 6-cycle window completes after release.
//  6 SENSOR_FAULT_LATCH_EN: after step 4, restore raw_m=1 -> level_err stays 1;
//    err_clr=1 -> level_err=0 next cycle.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and helpers for the sensor conditioner.
// Channel indices, debounce FSM states, tank-level plausibility.
package sensor_pkg;

  localparam int N_CH  = 6;
  localparam int CH_H  = 0;
  localparam int CH_M  = 1;
  localparam int CH_L  = 2;
  localparam int CH_US = 3;
  localparam int CH_UA = 4;
  localparam int CH_T  = 5;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

  // A level may only be set if every level below it is set too.
  function automatic logic level_valid(
    input logic h,
    input logic m,
    input logic l
  );
    return (!h || m) && (!m || l);
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Board-side bundle of raw switches and conditioned levels.
// err_clr exists only when SENSOR_FAULT_LATCH_EN is defined.
interface sensor_conditioner_if;

  logic raw_h;
  logic raw_m;
  logic raw_l;
  logic raw_us;
  logic raw_ua;
  logic raw_t;
  logic h;
  logic m;
  logic l;
  logic us;
  logic ua;
  logic t;
  logic changed;
  logic level_err;
`ifdef SENSOR_FAULT_LATCH_EN
  logic err_clr;
`endif

  modport master (
`ifdef SENSOR_FAULT_LATCH_EN
    output err_clr,
`endif
    output raw_h, raw_m, raw_l,
    output raw_us, raw_ua, raw_t,
    input  h, m, l, us, ua, t,
    input  changed, level_err
  );

  modport slave (
`ifdef SENSOR_FAULT_LATCH_EN
    input  err_clr,
`endif
    input  raw_h, raw_m, raw_l,
    input  raw_us, raw_ua, raw_t,
    output h, m, l, us, ua, t,
    output changed, level_err
  );

endinterface

// File: rtl/debounce_cell.sv
// One-bit synchroniser plus stable/pending debounce FSM.
// deb_o is the next stable value so the caller can register it.
module debounce_cell
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    unique case (state_q)
      ST_STABLE: begin
        if (sync != stable_q) begin
          state_d = ST_PENDING;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PENDING: begin
        if (sync == stable_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_d = sync;
          state_d  = ST_STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign deb_o = stable_d;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces six sensor switches and enforces a plausible tank pattern.
// Define SENSOR_FAULT_LATCH_EN for a sticky level_err cleared by err_clr.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input logic           clk,
  input logic           rst_n,
  sensor_conditioner_if.slave bus
);

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] deb;
  logic [2:0]      hml_q, hml_d;
  logic [2:0]      env_q, env_d;
  logic            err_q, err_d;
  logic            chg_q, chg_d;
  logic            lvl_ok;

  assign raw[CH_H]  = bus.raw_h;
  assign raw[CH_M]  = bus.raw_m;
  assign raw[CH_L]  = bus.raw_l;
  assign raw[CH_US] = bus.raw_us;
  assign raw[CH_UA] = bus.raw_ua;
  assign raw[CH_T]  = bus.raw_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw_i(raw[i]),
      .deb_o(deb[i])
    );
  end

  always_comb begin
    lvl_ok = level_valid(deb[CH_H], deb[CH_M], deb[CH_L]);
    hml_d  = lvl_ok ? {deb[CH_H], deb[CH_M], deb[CH_L]} : hml_q;
    env_d  = {deb[CH_US], deb[CH_UA], deb[CH_T]};
    chg_d  = (hml_d != hml_q) || (env_d != env_q);
`ifdef SENSOR_FAULT_LATCH_EN
    err_d = err_q;
    if (!lvl_ok)
      err_d = 1'b1;
    else if (bus.err_clr)
      err_d = 1'b0;
`else
    err_d = !lvl_ok;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hml_q <= '0;
      env_q <= '0;
      err_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      hml_q <= hml_d;
      env_q <= env_d;
      err_q <= err_d;
      chg_q <= chg_d;
    end
  end

  assign {bus.h, bus.m, bus.l}    = hml_q;
  assign {bus.us, bus.ua, bus.t}  = env_q;
  assign bus.changed              = chg_q;
  assign bus.level_err            = err_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed and random checks of sensor_conditioner against a sample-history model.
// Builds with or without SENSOR_FAULT_LATCH_EN.
module tb_sensor_conditioner;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int HLEN = SYNC + DEB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] raw;
  logic       clr;
  int         total = 0;
  int         bad   = 0;

  // model state
  bit       hist [6][HLEN];
  bit       deb_m [6];
  bit [2:0] hml_m;
  bit [2:0] env_m;
  bit       chg_m;
  bit       err_m;

  sensor_conditioner_if bus();

  assign bus.raw_h  = raw[0];
  assign bus.raw_m  = raw[1];
  assign bus.raw_l  = raw[2];
  assign bus.raw_us = raw[3];
  assign bus.raw_ua = raw[4];
  assign bus.raw_t  = raw[5];
`ifdef SENSOR_FAULT_LATCH_EN
  assign bus.err_clr = clr;
`endif

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 6; c++) begin
      deb_m[c] = 1'b0;
      for (int i = 0; i < HLEN; i++) hist[c][i] = 1'b0;
    end
    hml_m = '0;
    env_m = '0;
    chg_m = 1'b0;
    err_m = 1'b0;
  endtask

  // A level is accepted once the DEB samples that have crossed the
  // synchroniser all disagree with the currently accepted level.
  task automatic model_step();
    bit       differ;
    bit [2:0] pat, nh, ne;
    bit       ok;
    if (!rst_n) return;
    for (int c = 0; c < 6; c++) begin
      for (int i = HLEN - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = raw[c];
      differ = 1'b1;
      for (int i = SYNC; i < HLEN; i++)
        if (hist[c][i] == deb_m[c]) differ = 1'b0;
      if (differ) deb_m[c] = ~deb_m[c];
    end
    pat = {deb_m[0], deb_m[1], deb_m[2]};
    ok  = pat inside {3'b000, 3'b001, 3'b011, 3'b111};
    nh  = ok ? pat : hml_m;
    ne  = {deb_m[3], deb_m[4], deb_m[5]};
    chg_m = (nh != hml_m) || (ne != env_m);
    hml_m = nh;
    env_m = ne;
`ifdef SENSOR_FAULT_LATCH_EN
    if (!ok) err_m = 1'b1;
    else if (clr) err_m = 1'b0;
`else
    err_m = !ok;
`endif
  endtask

  function automatic logic [7:0] outs();
    return {bus.h, bus.m, bus.l, bus.us, bus.ua, bus.t,
            bus.changed, bus.level_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outs", outs(), {hml_m, env_m, chg_m, err_m});
  endtask

  initial begin
    raw   = 6'h3F;
    clr   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_zero", outs(), 8'h00);

    rst_n = 1'b1;
    repeat (5) tick();
    check("rel_env_early", 8'({bus.us, bus.ua, bus.t}), 8'b000);
    tick();
    check("rel_env_set", 8'({bus.us, bus.ua, bus.t, bus.changed}), 8'b1111);

    raw = 6'h00;
    repeat (10) tick();
    check("all_low", outs(), 8'h00);

    raw[3] = 1'b1;
    repeat (5) tick();
    check("us_early", 8'(bus.us), 8'd0);
    tick();
    check("us_rise", 8'({bus.us, bus.changed}), 8'b11);
    tick();
    check("chg_once", 8'(bus.changed), 8'd0);

    raw[5] = 1'b1;
    repeat (3) tick();
    raw[5] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch", 8'({bus.t, bus.changed}), 8'b00);
    end

    raw[2] = 1'b1;
    repeat (10) tick();
    check("lvl_001", 8'({bus.h, bus.m, bus.l, bus.level_err}), 8'b0010);
    raw[1] = 1'b1;
    repeat (10) tick();
    check("lvl_011", 8'({bus.h, bus.m, bus.l, bus.level_err}), 8'b0110);
    raw[0] = 1'b1;
    repeat (10) tick();
    check("lvl_111", 8'({bus.h, bus.m, bus.l, bus.level_err}), 8'b1110);
    raw[1] = 1'b0;
    repeat (10) tick();
    check("lvl_bad", 8'({bus.h, bus.m, bus.l, bus.level_err}), 8'b1111);

    raw[1] = 1'b1;
    repeat (10) tick();
`ifdef SENSOR_FAULT_LATCH_EN
    check("err_sticky", 8'(bus.level_err), 8'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("err_clr", 8'(bus.level_err), 8'd0);
`else
    check("err_follow", 8'(bus.level_err), 8'd0);
`endif

    raw[4] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    check("mid_rst", outs(), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ua_wait", 8'(bus.ua), 8'd0);
    end
    tick();
    check("ua_set", 8'(bus.ua), 8'd1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0)
        raw = 6'($urandom);
      else if ($urandom_range(0, 7) == 0)
        raw[$urandom_range(0, 5)] = ~raw[$urandom_range(0, 5)];
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
